memory_arbiter: RTL
===================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL take parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL take parameter DATA_W, default 32, word width.
REQ-003 SHALL take parameter STARVE_LIMIT, default 4, max consecutive data grants while iread is pending.
REQ-004 SHALL have port CLK  in  1  single clock, rising edge.
REQ-005 SHALL have port nRST  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports iread in 1 fetch request; iaddr in ADDR_W fetch address; iload out DATA_W fetch data; ihit out 1 fetch done pulse.
REQ-007 SHALL have ports dread in 1 load request; dwrite in 1 store request; daddr in ADDR_W; dstore in DATA_W; dload out DATA_W; dhit out 1 data done pulse.
REQ-008 SHALL have ports ram_ren out 1; ram_wen out 1; ram_addr out ADDR_W; ram_wdata out DATA_W; ram_rdata in DATA_W; ram_ready in 1 access-complete pulse from RAM.

Function
REQ-009 SHALL implement FSM states IDLE, IBUSY, DBUSY, in a 2-bit encoding.
REQ-010 In IDLE, SHALL grant data when (dread|dwrite) and starve_cnt<STARVE_LIMIT, else instruction when iread, else stay IDLE.
REQ-011 When starve_cnt==STARVE_LIMIT and iread is high, SHALL grant instruction even if a data request is pending.
REQ-012 On grant, SHALL register ram_addr, ram_wdata, and the access type at the clock edge, so requester changes after grant do not affect the access.
REQ-013 SHALL treat dread&dwrite as a write.
REQ-014 ram_ren SHALL be high in IBUSY and in DBUSY-read; ram_wen SHALL be high only in DBUSY-write; both SHALL be low in IDLE and never high together.
REQ-015 SHALL stay in a BUSY state until ram_ready=1, then go to IDLE, giving at least one IDLE cycle between accesses.
REQ-016 ihit SHALL equal (state==IBUSY)&ram_ready&iread, combinationally; dhit SHALL equal (state==DBUSY)&ram_ready&(dread|dwrite).
REQ-017 iload and dload SHALL pass ram_rdata through; they are meaningful only when the matching hit is high.
REQ-018 Minimum request-to-hit latency SHALL be 1 cycle plus RAM latency.
REQ-019 If the owning requester drops its request mid-access (for example a branch flush), SHALL finish the RAM access, suppress the hit, and return to IDLE.
REQ-020 starve_cnt SHALL increment (saturating at STARVE_LIMIT) on each data grant made while iread is high.
REQ-021 starve_cnt SHALL clear on any instruction grant and on any data grant made while iread is low.
REQ-022 ram_ready seen in IDLE SHALL be ignored.

Reset
REQ-023 On nRST low, SHALL force state to IDLE, starve_cnt to 0, and ram_addr and ram_wdata to 0, so that ram_ren=0, ram_wen=0, ihit=0, dhit=0 asynchronously.
REQ-024 Reset asserted mid-access SHALL abandon the access; a later ram_ready SHALL be ignored under REQ-022.

Structure
REQ-025 The arbiter state enum SHALL be a typedef in common_types_pkg; word and address typedefs SHALL come from the same package.
REQ-026 SHALL be a single module with no sub-modules; the starvation counter is inline.

Verification
REQ-027 Reset: nRST low during DBUSY -> next cycle ram_ren=ram_wen=0, ihit=dhit=0, state IDLE.
REQ-028 Single fetch: iread=1, iaddr=0x100, RAM ready 2 cycles after ram_ren with rdata=0xDEADBEEF -> ihit pulses once with iload=0xDEADBEEF, 3 cycles after the request.
REQ-029 Collision: iread and dwrite both high in IDLE, daddr=0x200, dstore=0x5 -> data served first (ram_wen, ram_addr=0x200, ram_wdata=0x5); dhit, then one IDLE cycle, then an instruction grant.
REQ-030 Starvation: iread held high, dread held high continuously -> after 4 data grants the 5th grant goes to instruction; starve_cnt returns to 0.
REQ-031 Flush abort: iread dropped one cycle after the IBUSY grant, ram_ready arrives later -> ihit stays 0, arbiter returns to IDLE, and the next dread is granted.
REQ-032 Address stability: daddr changed from 0x300 to 0x304 during DBUSY -> ram_addr stays 0x300 until ram_ready.

Source files
------------

// File: rtl/common_types_pkg.sv
// Shared types for the memory arbiter: arbiter state encoding plus word/address types.
package common_types_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        IBUSY = 2'b01,
        DBUSY = 2'b10
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Arbitrates one single-port RAM between an instruction fetch port and a data load/store port,
// with data priority bounded by a starvation counter that guarantees fetch progress.
module memory_arbiter
    import common_types_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iread,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              ihit,
    input  logic              dread,
    input  logic              dwrite,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dhit,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t       state;
    arb_state_t       next_state;
    logic [CNT_W-1:0] starve_cnt;
    logic             is_write;
    logic             data_req;
    logic             starved;
    logic             grant_d;
    logic             grant_i;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == LIMIT) ? v : v + CNT_W'(1);
    endfunction

    assign data_req = dread | dwrite;
    // A saturated counter only blocks data while a fetch is actually waiting.
    assign starved  = (starve_cnt == LIMIT) && iread;
    assign grant_d  = (state == IDLE) && data_req && !starved;
    assign grant_i  = (state == IDLE) && !grant_d && iread;

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant_d)      next_state = DBUSY;
                else if (grant_i) next_state = IBUSY;
            end
            IBUSY, DBUSY: begin
                if (ram_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ram_ren = 1'b0;
        ram_wen = 1'b0;
        ihit    = 1'b0;
        dhit    = 1'b0;
        case (state)
            IBUSY: begin
                ram_ren = 1'b1;
                ihit    = ram_ready & iread;
            end
            DBUSY: begin
                ram_ren = !is_write;
                ram_wen = is_write;
                dhit    = ram_ready & data_req;
            end
            default: ;
        endcase
    end

    assign iload = ram_rdata;
    assign dload = ram_rdata;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            is_write   <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
        end else begin
            state <= next_state;
            // Access parameters are captured at grant so requester changes cannot disturb the RAM.
            if (grant_d) begin
                is_write   <= dwrite;
                ram_addr   <= daddr;
                ram_wdata  <= dstore;
                starve_cnt <= iread ? sat_inc(starve_cnt) : '0;
            end else if (grant_i) begin
                is_write   <= 1'b0;
                ram_addr   <= iaddr;
                starve_cnt <= '0;
            end
        end
    end

endmodule
